// File: rtl/move_executor_if.sv
// move_executor_if: request/obstacle inputs and position/result outputs of the move executor
interface move_executor_if;
  logic move_valid;
  logic move_ready;
  logic [3:0] move_dir;
  logic [3:0] blocked;
  logic [3:0] pos_x;
  logic [3:0] pos_y;
  logic move_done;
  logic move_rejected;
  modport master (
    output move_valid, move_dir, blocked,
    input move_ready, pos_x, pos_y, move_done, move_rejected
  );
  modport slave (
    input move_valid, move_dir, blocked,
    output move_ready, pos_x, pos_y, move_done, move_rejected
  );
endinterface

// File: rtl/move_executor.sv
// move_executor: validates one-hot move requests against map bounds and obstacles, owns player position
module move_executor #(
  parameter int MAP_WIDTH = 16,
  parameter int MAP_HEIGHT = 16,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int COOLDOWN_CYCLES = 4
) (
  input logic clk,
  input logic rst_n,
  input logic respawn,
  move_executor_if.slave bus
);
  localparam int CW = COOLDOWN_CYCLES > 0 ? $clog2(COOLDOWN_CYCLES + 1) : 1;
  localparam logic [3:0] X_MAX = 4'(MAP_WIDTH - 1);
  localparam logic [3:0] Y_MAX = 4'(MAP_HEIGHT - 1);
  localparam logic [3:0] X0 = 4'(START_X);
  localparam logic [3:0] Y0 = 4'(START_Y);
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_CYCLES > 0 ? COOLDOWN_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, CHECK, COOLDOWN} state_t;
  state_t state_q;
  logic [3:0] dir_q, x_q, y_q, x_d, y_d, allow;
  logic [CW-1:0] cnt_q;
  logic done_q, rej_q, legal;
  always_comb begin
    allow = {x_q != X_MAX, y_q != 4'd0, y_q != Y_MAX, x_q != 4'd0} & ~bus.blocked;
    legal = $onehot(dir_q) && |(dir_q & allow);
    x_d = dir_q[3] ? x_q + 4'd1 : dir_q[0] ? x_q - 4'd1 : x_q;
    y_d = dir_q[1] ? y_q + 4'd1 : dir_q[2] ? y_q - 4'd1 : y_q;
  end
  // respawn is a reset of the game state only, so it shares the reset action
  always_ff @(posedge clk)
    if (!rst_n || respawn) begin
      state_q <= IDLE;
      x_q <= X0;
      y_q <= Y0;
      dir_q <= 4'd0;
      cnt_q <= '0;
      done_q <= 1'b0;
      rej_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rej_q <= 1'b0;
      unique case (state_q)
        IDLE: if (bus.move_valid) begin
          dir_q <= bus.move_dir;
          state_q <= CHECK;
        end
        CHECK: begin
          done_q <= legal;
          rej_q <= !legal;
          if (legal) begin
            x_q <= x_d;
            y_q <= y_d;
            cnt_q <= CD_LOAD;
          end
          state_q <= legal && (COOLDOWN_CYCLES > 0) ? COOLDOWN : IDLE;
        end
        COOLDOWN: begin
          cnt_q <= cnt_q - CW'(1);
          state_q <= cnt_q == '0 ? IDLE : COOLDOWN;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign bus.move_ready = state_q == IDLE;
  assign bus.pos_x = x_q;
  assign bus.pos_y = y_q;
  assign bus.move_done = done_q;
  assign bus.move_rejected = rej_q;
endmodule

// File: tb/tb_move_executor.sv
// tb_move_executor: directed scoreboard bench; dut_a starts at (3,5) with cooldown 4, dut_b at (0,0) with no cooldown
module tb_move_executor;
  typedef struct packed {logic done; logic [3:0] x; logic [3:0] y;} exp_t;
  logic clk = 1'b0;
  logic rst_a_n, rst_b_n, resp_a, resp_b;
  int checks = 0;
  int failures = 0;
  exp_t qa[$];
  exp_t qb[$];
  move_executor_if ia();
  move_executor_if ib();
  move_executor #(.START_X(3), .START_Y(5), .COOLDOWN_CYCLES(4)) dut_a (
    .clk(clk), .rst_n(rst_a_n), .respawn(resp_a), .bus(ia)
  );
  move_executor #(.START_X(0), .START_Y(0), .COOLDOWN_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_b_n), .respawn(resp_b), .bus(ib)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  function automatic logic rdy(input bit b);
    return b ? ib.move_ready : ia.move_ready;
  endfunction
  task automatic drive(input bit b, input logic v, input logic [3:0] d, input logic [3:0] k);
    if (b) begin
      ib.move_valid = v; ib.move_dir = d; ib.blocked = k;
    end else begin
      ia.move_valid = v; ia.move_dir = d; ia.blocked = k;
    end
  endtask
  // waits (bounded) for ready, offers one request and returns at the negedge inside CHECK
  task automatic accept(input bit b, input logic [3:0] d, input logic [3:0] k);
    int n = 0;
    while (!rdy(b) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", n < 50, 1);
    drive(b, 1'b1, d, k);
    @(negedge clk);
    drive(b, 1'b0, d, k);
    chk("busy_in_check", rdy(b), 0);
  endtask
  task automatic req(input bit b, input logic [3:0] d, input logic [3:0] k, input logic ok,
                     input logic [3:0] ex, input logic [3:0] ey);
    exp_t e;
    e = '{done: ok, x: ex, y: ey};
    if (b) qb.push_back(e); else qa.push_back(e);
    accept(b, d, k);
    @(negedge clk);
    drive(b, 1'b0, 4'd0, 4'd0);
    chk("ready_after_result", rdy(b), !ok || b);
  endtask
  always @(negedge clk) if (ia.move_done || ia.move_rejected) begin
    exp_t e;
    chk("a_pulse_exclusive", ia.move_done & ia.move_rejected, 0);
    chk("a_pulse_expected", qa.size() != 0, 1);
    if (qa.size() != 0) begin
      e = qa.pop_front();
      chk("a_kind_done", ia.move_done, e.done);
      chk("a_pos_x", ia.pos_x, e.x);
      chk("a_pos_y", ia.pos_y, e.y);
    end
  end
  always @(negedge clk) if (ib.move_done || ib.move_rejected) begin
    exp_t e;
    chk("b_pulse_exclusive", ib.move_done & ib.move_rejected, 0);
    chk("b_pulse_expected", qb.size() != 0, 1);
    if (qb.size() != 0) begin
      e = qb.pop_front();
      chk("b_kind_done", ib.move_done, e.done);
      chk("b_pos_x", ib.pos_x, e.x);
      chk("b_pos_y", ib.pos_y, e.y);
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    rst_a_n = 1'b0; rst_b_n = 1'b0; resp_a = 1'b0; resp_b = 1'b0;
    drive(0, 1'b0, 4'd0, 4'd0);
    drive(1, 1'b0, 4'd0, 4'd0);
    repeat (2) @(negedge clk);
    rst_a_n = 1'b1; rst_b_n = 1'b1;
    @(negedge clk);
    chk("rst_pos_x", ia.pos_x, 3);
    chk("rst_pos_y", ia.pos_y, 5);
    chk("rst_ready", ia.move_ready, 1);
    chk("rst_done", ia.move_done, 0);
    chk("rst_rejected", ia.move_rejected, 0);
    chk("rst_b_pos", {ib.pos_x, ib.pos_y}, 0);
    req(0, 4'b1000, 4'd0, 1, 4, 5);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk("cooldown_busy", ia.move_ready, 0);
    end
    @(negedge clk);
    chk("cooldown_over", ia.move_ready, 1);
    req(0, 4'b0010, 4'b0010, 0, 4, 5);
    req(0, 4'b0000, 4'd0, 0, 4, 5);
    req(0, 4'b0011, 4'd0, 0, 4, 5);
    req(0, 4'b0010, 4'b1101, 1, 4, 6);
    for (int x = 5; x <= 7; x++) req(0, 4'b1000, 4'd0, 1, 4'(x), 6);
    req(0, 4'b0010, 4'd0, 1, 7, 7);
    accept(0, 4'b0100, 4'd0);
    resp_a = 1'b1;
    @(negedge clk);
    resp_a = 1'b0;
    chk("respawn_pos", {ia.pos_x, ia.pos_y}, {4'd3, 4'd5});
    chk("respawn_ready", ia.move_ready, 1);
    @(negedge clk);
    chk("respawn_hold_pos", {ia.pos_x, ia.pos_y}, {4'd3, 4'd5});
    req(0, 4'b1000, 4'd0, 1, 4, 5);
    accept(0, 4'b1000, 4'd0);
    rst_a_n = 1'b0;
    @(negedge clk);
    rst_a_n = 1'b1;
    chk("reset_abort_pos", {ia.pos_x, ia.pos_y}, {4'd3, 4'd5});
    chk("reset_abort_ready", ia.move_ready, 1);
    @(negedge clk);
    chk("reset_abort_hold", {ia.pos_x, ia.pos_y}, {4'd3, 4'd5});
    req(1, 4'b0001, 4'd0, 0, 0, 0);
    req(1, 4'b0100, 4'd0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) qb.push_back('{done: 1'b1, x: 4'd0, y: 4'(k)});
    drive(1, 1'b1, 4'b0010, 4'd0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("bp_busy", ib.move_ready, 0);
      chk("bp_hold_y", ib.pos_y, k - 1);
      @(negedge clk);
      chk("bp_step_y", ib.pos_y, k);
      chk("bp_ready", ib.move_ready, 1);
    end
    drive(1, 1'b0, 4'd0, 4'd0);
    for (int x = 1; x <= 15; x++) req(1, 4'b1000, 4'd0, 1, 4'(x), 3);
    for (int y = 4; y <= 15; y++) req(1, 4'b0010, 4'd0, 1, 15, 4'(y));
    req(1, 4'b1000, 4'd0, 0, 15, 15);
    req(1, 4'b0010, 4'd0, 0, 15, 15);
    req(1, 4'b0001, 4'd0, 1, 14, 15);
    repeat (3) @(negedge clk);
    chk("a_scoreboard_empty", qa.size(), 0);
    chk("b_scoreboard_empty", qb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/move_executor.md
# move_executor

Sequential consumer of the four-direction move encoding used by the game logic. It accepts one-hot move requests through a valid/ready handshake and validates each request against the map boundary and an external obstacle mask. Legal moves update the registered player position; illegal ones are reported as rejections. After a successful step it enforces a cooldown. It sits between the input/key-decode stage and the renderer/game-state logic, and it is the sole owner of the player position.

## Interface
- `MAP_WIDTH`, default 16: map columns. Legal range 1..16.
- `MAP_HEIGHT`, default 16: map rows. Legal range 1..16.
- `START_X`, default 0: x coordinate loaded on reset and on respawn. Must be less than `MAP_WIDTH`.
- `START_Y`, default 0: y coordinate loaded on reset and on respawn. Must be less than `MAP_HEIGHT`.
- `COOLDOWN_CYCLES`, default 4: idle cycles enforced after each successful move. 0 is legal.
- `clk`  in  1  system clock. Single clock domain.
- `rst_n`  in  1  reset, synchronous, active-low.
- `respawn`  in  1  single-cycle pulse. Reloads `START_X`/`START_Y` and aborts any in-flight request.
- `move_valid`  in  1  a move request is present.
- `move_ready`  out  1  block can accept a request. High only in IDLE.
- `move_dir`  in  4  direction, `{right, up, down, left}`. Bit0 = left (x-1), bit1 = down (y+1), bit2 = up (y-1), bit3 = right (x+1).
- `blocked`  in  4  obstacle mask, same bit order. Driven by the map lookup for the current position. Sampled in CHECK.
- `pos_x`  out  4  registered player x.
- `pos_y`  out  4  registered player y.
- `move_done`  out  1  one-cycle pulse: move applied.
- `move_rejected`  out  1  one-cycle pulse: move refused.

## Operation
- States: IDLE, CHECK, COOLDOWN.
- Reset (`rst_n`=0 at a clock edge):
  - state = IDLE.
  - `pos_x` = `START_X`, `pos_y` = `START_Y`.
  - `move_done` = 0, `move_rejected` = 0.
  - latched direction = 0, cooldown counter = 0.
  - `move_ready` = 1 from the first cycle after reset.
- IDLE:
  - `move_ready` = 1.
  - When `move_valid` && `move_ready` at an edge: latch `move_dir` and go to CHECK.
  - `move_valid` is ignored while `move_ready` = 0. There is no queuing.
- CHECK: compute the allow mask.
  - left allowed if x ≠ 0.
  - down allowed if y ≠ `MAP_HEIGHT`-1.
  - up allowed if y ≠ 0.
  - right allowed if x ≠ `MAP_WIDTH`-1.
  - Each direction is then masked with `~blocked`.
- CHECK outcome, legal: the latched direction is exactly one-hot and its allow bit is 1.
  - Update the position at the edge leaving CHECK.
  - Pulse `move_done`.
  - Go to COOLDOWN, loading the counter with `COOLDOWN_CYCLES`-1. If `COOLDOWN_CYCLES` = 0, go straight to IDLE.
- CHECK outcome, illegal: direction is zero, multi-hot, or not allowed.
  - Position is unchanged.
  - Pulse `move_rejected`.
  - Go to IDLE.
- COOLDOWN: decrement the counter each cycle. When the counter reads 0, go to IDLE.
- Arithmetic: 4-bit unsigned.
  - The boundary check guarantees no wrap. x = 0 never decrements; x = 15 never increments when `MAP_WIDTH` = 16.
  - The cooldown counter width is `$clog2(COOLDOWN_CYCLES+1)`, minimum 1 bit.
- Respawn (`respawn` = 1 at an edge, any state):
  - Load the start position and go to IDLE.
  - Clear the counter and the latched direction.
  - Suppress `move_done`/`move_rejected` for that edge.
  - Respawn takes priority over a simultaneous handshake or CHECK result. A request offered in the same cycle is not accepted.
- Reset has priority over respawn.
- Reset mid-operation aborts the request with no pulse.

## Timing
- Handshake accepted at edge E0 (IDLE → CHECK). `move_ready` = 0 in the cycle after E0.
- `blocked` must be valid during the CHECK cycle; it is sampled at edge E1.
- The new `pos_x`/`pos_y` and `move_done` (or `move_rejected`) are visible after E1.
  - Latency from request acceptance to result is 2 cycles.
  - Each pulse is exactly 1 cycle wide.
- After a rejection, `move_ready` = 1 in the same cycle as the `move_rejected` pulse.
- After a done, `move_ready` returns exactly `COOLDOWN_CYCLES` cycles after the `move_done` cycle. It is coincident with `move_done` if `COOLDOWN_CYCLES` = 0.
- Maximum throughput: one move per 2 + `COOLDOWN_CYCLES` cycles.
- `move_done` and `move_rejected` are never high in the same cycle.
- `pos_x`/`pos_y` change only on the legal-CHECK edge, respawn, or reset.

## Test plan
- Reset with `START_X`=3, `START_Y`=5: pos reads (3,5), `move_ready`=1, both pulses 0.
- Legal move: from (3,5) send `move_dir`=4'b1000, `blocked`=0.
  - Pos becomes (4,5) two cycles after acceptance, with `move_done` high for 1 cycle.
  - `move_ready` low for exactly 4 cycles after that, with `COOLDOWN_CYCLES`=4.
- Boundary and obstacle rejections, each giving `move_rejected` 2 cycles after acceptance, pos unchanged, `move_ready` back in the same cycle:
  - At (0,0), `move_dir`=4'b0001 (left).
  - At (0,0), `move_dir`=4'b0100 (up).
  - At (15,15) with a 16x16 map, `move_dir`=4'b1000 (right).
  - `move_dir`=4'b0010 with `blocked`=4'b0010.
- Malformed direction: `move_dir`=4'b0000 and `move_dir`=4'b0011 → `move_rejected` each time, pos unchanged.
- Back-pressure: hold `move_valid`=1 continuously with `move_dir`=4'b0010 from (0,0), `COOLDOWN_CYCLES`=0.
  - Pos steps y = 1, 2, 3 on every second cycle.
  - No request is accepted while `move_ready`=0.
- Respawn: assert `respawn` during CHECK of a legal move from (7,7).
  - Pos becomes (START_X, START_Y) and state returns to IDLE.
  - No `move_done`, no position step.
  - Repeat the test with `rst_n`=0 instead of `respawn`: same abort result.
